// File: rtl/histogram_sira_denetleyici.sv
// Frame sequencer for a 256-bin pixel histogram: clears the bin RAM, accumulates one frame with
// forwarded read-modify-write, then streams every bin together with its running cumulative sum.
module histogram_sira_denetleyici #(
  parameter int unsigned PIXEL_BIT    = 8,
  parameter int unsigned SAYAC_BIT    = 17,
  parameter int unsigned PIXEL_SAYISI = 76800
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 baslat_i,
  input  logic                 pixel_gecerli_i,
  input  logic [PIXEL_BIT-1:0] pixel_i,
  output logic                 pixel_hazir_o,
  output logic [PIXEL_BIT-1:0] bellek_oku_adres_o,
  input  logic [SAYAC_BIT-1:0] bellek_oku_veri_i,
  output logic                 bellek_yaz_en_o,
  output logic [PIXEL_BIT-1:0] bellek_yaz_adres_o,
  output logic [SAYAC_BIT-1:0] bellek_yaz_veri_o,
  output logic                 kutu_gecerli_o,
  input  logic                 kutu_hazir_i,
  output logic [PIXEL_BIT-1:0] kutu_adres_o,
  output logic [SAYAC_BIT-1:0] kutu_deger_o,
  output logic [SAYAC_BIT-1:0] kumulatif_o,
  output logic                 son_o,
  output logic                 mesgul_o,
  output logic                 tamam_o
);

  localparam logic [PIXEL_BIT-1:0] SonKutu   = '1;
  localparam logic [SAYAC_BIT-1:0] SonPiksel = SAYAC_BIT'(PIXEL_SAYISI - 1);

  typedef enum logic [2:0] {
    StBosta,
    StTemizle,
    StTopla,
    StBosalt,
    StOkuAdres,
    StOkuVeri,
    StCikis,
    StTamam
  } durum_e;

  durum_e               durum_q, durum_d;
  logic [PIXEL_BIT-1:0] temiz_adres_q, temiz_adres_d;
  logic [SAYAC_BIT-1:0] pix_say_q, pix_say_d;
  logic [PIXEL_BIT-1:0] kutu_q, kutu_d;
  logic [PIXEL_BIT-1:0] kutu_adres_q, kutu_adres_d;
  logic [SAYAC_BIT-1:0] kutu_deger_q, kutu_deger_d;
  logic [SAYAC_BIT-1:0] kum_q, kum_d;

  // Accumulate pipeline: A issues the read, B adds one and writes back.
  logic                 a_gecerli_q;
  logic [PIXEL_BIT-1:0] a_adres_q;
  logic                 b_gecerli_q;
  logic [PIXEL_BIT-1:0] b_adres_q;
  logic                 yaz_gecerli_q;
  logic [PIXEL_BIT-1:0] yaz_adres_q;
  logic [SAYAC_BIT-1:0] yaz_veri_q;

  logic                 kabul;
  logic [SAYAC_BIT-1:0] b_sayi;
  logic [SAYAC_BIT-1:0] b_yeni;

  assign kabul = pixel_gecerli_i && (durum_q == StTopla);

  // The RAM returns old data on read-during-write, so the write from the previous cycle is the
  // only one the read in stage A could have missed.
  assign b_sayi = (yaz_gecerli_q && (yaz_adres_q == b_adres_q)) ? yaz_veri_q : bellek_oku_veri_i;
  assign b_yeni = b_sayi + SAYAC_BIT'(1);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      a_gecerli_q   <= 1'b0;
      a_adres_q     <= '0;
      b_gecerli_q   <= 1'b0;
      b_adres_q     <= '0;
      yaz_gecerli_q <= 1'b0;
      yaz_adres_q   <= '0;
      yaz_veri_q    <= '0;
    end else begin
      a_gecerli_q   <= kabul;
      if (kabul) begin
        a_adres_q <= pixel_i;
      end
      b_gecerli_q   <= a_gecerli_q;
      b_adres_q     <= a_adres_q;
      yaz_gecerli_q <= b_gecerli_q;
      yaz_adres_q   <= b_adres_q;
      yaz_veri_q    <= b_yeni;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      durum_q       <= StBosta;
      temiz_adres_q <= '0;
      pix_say_q     <= '0;
      kutu_q        <= '0;
      kutu_adres_q  <= '0;
      kutu_deger_q  <= '0;
      kum_q         <= '0;
    end else begin
      durum_q       <= durum_d;
      temiz_adres_q <= temiz_adres_d;
      pix_say_q     <= pix_say_d;
      kutu_q        <= kutu_d;
      kutu_adres_q  <= kutu_adres_d;
      kutu_deger_q  <= kutu_deger_d;
      kum_q         <= kum_d;
    end
  end

  always_comb begin
    durum_d       = durum_q;
    temiz_adres_d = temiz_adres_q;
    pix_say_d     = pix_say_q;
    kutu_d        = kutu_q;
    kutu_adres_d  = kutu_adres_q;
    kutu_deger_d  = kutu_deger_q;
    kum_d         = kum_q;
    unique case (durum_q)
      StBosta: begin
        if (baslat_i) begin
          durum_d       = StTemizle;
          temiz_adres_d = '0;
        end
      end
      StTemizle: begin
        temiz_adres_d = temiz_adres_q + PIXEL_BIT'(1);
        if (temiz_adres_q == SonKutu) begin
          durum_d   = StTopla;
          pix_say_d = '0;
        end
      end
      StTopla: begin
        if (kabul) begin
          if (pix_say_q == SonPiksel) begin
            durum_d = StBosalt;
          end else begin
            pix_say_d = pix_say_q + SAYAC_BIT'(1);
          end
        end
      end
      StBosalt: begin
        // Last writes must land before readout reads the same bins.
        if (!a_gecerli_q && !b_gecerli_q) begin
          durum_d = StOkuAdres;
          kutu_d  = '0;
          kum_d   = '0;
        end
      end
      StOkuAdres: begin
        durum_d = StOkuVeri;
      end
      StOkuVeri: begin
        kutu_deger_d = bellek_oku_veri_i;
        kutu_adres_d = kutu_q;
        kum_d        = kum_q + bellek_oku_veri_i;
        durum_d      = StCikis;
      end
      StCikis: begin
        if (kutu_hazir_i) begin
          if (kutu_q == SonKutu) begin
            durum_d = StTamam;
          end else begin
            kutu_d  = kutu_q + PIXEL_BIT'(1);
            durum_d = StOkuAdres;
          end
        end
      end
      StTamam: begin
        durum_d = StBosta;
      end
      default: begin
        durum_d = StBosta;
      end
    endcase
  end

  always_comb begin
    bellek_yaz_en_o    = 1'b0;
    bellek_yaz_adres_o = b_adres_q;
    bellek_yaz_veri_o  = b_yeni;
    if (durum_q == StTemizle) begin
      bellek_yaz_en_o    = 1'b1;
      bellek_yaz_adres_o = temiz_adres_q;
      bellek_yaz_veri_o  = '0;
    end else if (b_gecerli_q) begin
      bellek_yaz_en_o = 1'b1;
    end
  end

  assign bellek_oku_adres_o = (durum_q == StOkuAdres) ? kutu_q : a_adres_q;
  assign pixel_hazir_o      = (durum_q == StTopla);
  assign mesgul_o           = (durum_q != StBosta);
  assign kutu_gecerli_o     = (durum_q == StCikis);
  assign son_o              = (durum_q == StCikis) && (kutu_q == SonKutu);
  assign tamam_o            = (durum_q == StTamam);
  assign kutu_adres_o       = kutu_adres_q;
  assign kutu_deger_o       = kutu_deger_q;
  assign kumulatif_o        = kum_q;

endmodule

// File: tb/tb_histogram_sira_denetleyici.sv
// Directed bench for histogram_sira_denetleyici with a behavioural old-data dual-port bin RAM.
module tb_histogram_sira_denetleyici;

  localparam int unsigned PB = 8;
  localparam int unsigned SB = 17;
  localparam int unsigned N  = 768;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          baslat = 1'b0;
  logic          pix_gecerli = 1'b0;
  logic [PB-1:0] pix = '0;
  logic          pix_hazir;
  logic [PB-1:0] oku_adres;
  logic [SB-1:0] oku_veri;
  logic          yaz_en;
  logic [PB-1:0] yaz_adres;
  logic [SB-1:0] yaz_veri;
  logic          kutu_gecerli;
  logic          kutu_hazir = 1'b1;
  logic [PB-1:0] kutu_adres;
  logic [SB-1:0] kutu_deger;
  logic [SB-1:0] kumulatif;
  logic          son;
  logic          mesgul;
  logic          tamam;

  logic [SB-1:0] mem [256];

  int hata = 0;
  int toplam = 0;
  int model [256];
  int got_deger [256];
  int got_kum [256];

  histogram_sira_denetleyici #(
    .PIXEL_BIT   (PB),
    .SAYAC_BIT   (SB),
    .PIXEL_SAYISI(N)
  ) u_dut (
    .clk_i             (clk),
    .rstn_i            (rstn),
    .baslat_i          (baslat),
    .pixel_gecerli_i   (pix_gecerli),
    .pixel_i           (pix),
    .pixel_hazir_o     (pix_hazir),
    .bellek_oku_adres_o(oku_adres),
    .bellek_oku_veri_i (oku_veri),
    .bellek_yaz_en_o   (yaz_en),
    .bellek_yaz_adres_o(yaz_adres),
    .bellek_yaz_veri_o (yaz_veri),
    .kutu_gecerli_o    (kutu_gecerli),
    .kutu_hazir_i      (kutu_hazir),
    .kutu_adres_o      (kutu_adres),
    .kutu_deger_o      (kutu_deger),
    .kumulatif_o       (kumulatif),
    .son_o             (son),
    .mesgul_o          (mesgul),
    .tamam_o           (tamam)
  );

  always #5 clk = ~clk;

  // Registered read returning old data on a same-address write.
  always @(posedge clk) begin
    oku_veri <= mem[oku_adres];
    if (yaz_en) mem[yaz_adres] <= yaz_veri;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    toplam++;
    if (got !== exp) begin
      hata++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [PB-1:0] desen(input int mod, input int idx);
    case (mod)
      1:       desen = PB'(idx % 256);
      2:       desen = ((idx % 6) == 3 || (idx % 6) == 5) ? PB'(9) : PB'(7);
      3:       desen = PB'(255);
      default: desen = PB'(0);
    endcase
  endfunction

  task automatic wait_hazir(output int bekle);
    bekle = 0;
    while (!pix_hazir && bekle < 1000) begin
      @(negedge clk);
      bekle++;
    end
  endtask

  // mod: pixel pattern; bosluk: idle cycle between pixels; geri_bas: random ready;
  // cop: keep valid high with pixel 5 outside accumulation.
  task automatic run_frame(input int mod, input bit bosluk, input bit geri_bas, input bit cop);
    int bekle, idx, tur, k, sum, tamam_say;
    bit stall_prev;
    logic [PB-1:0] h_adres;
    logic [SB-1:0] h_deger, h_kum;
    logic h_son;
    for (int i = 0; i < 256; i++) begin
      model[i] = 0;
      got_deger[i] = -1;
      got_kum[i] = -1;
    end
    @(negedge clk);
    baslat = 1'b1;
    if (cop) begin
      pix_gecerli = 1'b1;
      pix = PB'(5);
    end
    @(negedge clk);
    baslat = 1'b0;
    check("temizle_mesgul", mesgul, 1);
    check("temizle_yaz_en", yaz_en, 1);
    check("temizle_ilk_adres", yaz_adres, 0);
    wait_hazir(bekle);
    check("hazir_gecikme", bekle, 256);

    idx = 0;
    tur = 0;
    while (idx < N && tur < 4 * N) begin
      if (bosluk && (tur % 2 == 1)) begin
        pix_gecerli = 1'b0;
      end else begin
        pix_gecerli = 1'b1;
        pix = desen(mod, idx);
      end
      baslat = (mod == 3 && idx == 100) ? 1'b1 : 1'b0;
      if (pix_gecerli && pix_hazir) begin
        model[pix]++;
        idx++;
      end
      @(negedge clk);
      tur++;
    end
    baslat = 1'b0;
    check("kabul_sayisi", idx, N);
    check("hazir_duser", pix_hazir, 0);
    if (cop) pix = PB'(5);
    else pix_gecerli = 1'b0;

    k = 0;
    sum = 0;
    tur = 0;
    tamam_say = 0;
    stall_prev = 1'b0;
    while (k < 256 && tur < 20000) begin
      if (stall_prev) begin
        check("tut_gecerli", kutu_gecerli, 1);
        check("tut_adres", kutu_adres, h_adres);
        check("tut_deger", kutu_deger, h_deger);
        check("tut_kum", kumulatif, h_kum);
        check("tut_son", son, h_son);
      end
      if (tamam) tamam_say++;
      kutu_hazir = geri_bas ? ($urandom_range(0, 9) >= 3) : 1'b1;
      stall_prev = 1'b0;
      if (kutu_gecerli && kutu_hazir) begin
        sum += model[k];
        check("kutu_adres", kutu_adres, k);
        check("kutu_deger", kutu_deger, model[k]);
        check("kumulatif", kumulatif, sum);
        check("son", son, (k == 255) ? 1 : 0);
        got_deger[k] = int'(kutu_deger);
        got_kum[k] = int'(kumulatif);
        k++;
      end else if (kutu_gecerli) begin
        stall_prev = 1'b1;
        h_adres = kutu_adres;
        h_deger = kutu_deger;
        h_kum = kumulatif;
        h_son = son;
      end
      @(negedge clk);
      tur++;
    end
    kutu_hazir = 1'b1;
    check("kutu_sayisi", k, 256);
    check("erken_tamam", tamam_say, 0);
    check("tamam_darbe", tamam, 1);
    check("tamam_gecerli", kutu_gecerli, 0);
    @(negedge clk);
    check("tamam_tek", tamam, 0);
    check("bosta_mesgul", mesgul, 0);
    pix_gecerli = 1'b0;
  endtask

  initial begin
    int bekle, gonder;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mesgul", mesgul, 0);
    check("rst_hazir", pix_hazir, 0);
    check("rst_yaz_en", yaz_en, 0);
    check("rst_gecerli", kutu_gecerli, 0);
    check("rst_tamam", tamam, 0);
    check("rst_son", son, 0);
    check("rst_kum", kumulatif, 0);
    check("rst_deger", kutu_deger, 0);
    rstn = 1'b1;
    @(negedge clk);

    run_frame(0, 1'b0, 1'b0, 1'b1);
    check("sifir_kutu0", got_deger[0], N);
    check("sifir_kutu5", got_deger[5], 0);
    check("sifir_kum0", got_kum[0], N);
    check("sifir_kum255", got_kum[255], N);

    run_frame(1, 1'b0, 1'b0, 1'b0);
    check("rampa_kutu0", got_deger[0], 3);
    check("rampa_kutu255", got_deger[255], 3);
    check("rampa_kum99", got_kum[99], 300);
    check("rampa_kum255", got_kum[255], N);

    run_frame(2, 1'b0, 1'b0, 1'b0);
    check("hazard_kutu7", got_deger[7], 512);
    check("hazard_kutu9", got_deger[9], 256);
    check("hazard_kutu8", got_deger[8], 0);

    run_frame(2, 1'b1, 1'b0, 1'b0);
    check("bosluk_kutu7", got_deger[7], 512);
    check("bosluk_kutu9", got_deger[9], 256);

    run_frame(1, 1'b0, 1'b1, 1'b0);
    check("geribas_kutu128", got_deger[128], 3);
    check("geribas_kum99", got_kum[99], 300);
    check("geribas_kum255", got_kum[255], N);

    run_frame(3, 1'b0, 1'b0, 1'b0);
    check("ikinci_kutu255", got_deger[255], N);
    check("ikinci_kutu0", got_deger[0], 0);
    check("ikinci_kutu7", got_deger[7], 0);

    // Abort a frame partway through accumulation.
    @(negedge clk);
    baslat = 1'b1;
    @(negedge clk);
    baslat = 1'b0;
    wait_hazir(bekle);
    check("iptal_hazir_gecikme", bekle, 256);
    gonder = 0;
    while (gonder < 500 && pix_hazir) begin
      pix_gecerli = 1'b1;
      pix = PB'(gonder % 256);
      gonder++;
      @(negedge clk);
    end
    check("iptal_gonderilen", gonder, 500);
    rstn = 1'b0;
    pix_gecerli = 1'b0;
    @(negedge clk);
    check("iptal_mesgul", mesgul, 0);
    check("iptal_hazir", pix_hazir, 0);
    check("iptal_yaz_en", yaz_en, 0);
    check("iptal_gecerli", kutu_gecerli, 0);
    rstn = 1'b1;
    @(negedge clk);

    run_frame(1, 1'b0, 1'b0, 1'b0);
    check("yeniden_kutu0", got_deger[0], 3);
    check("yeniden_kum255", got_kum[255], N);

    $display("Result: errors=%0d of %0d checks", hata, toplam);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
